// File: rtl/pkt_gen_csr_pkg.sv
// pkt_gen_csr_pkg
// Shared definitions for the pkt_gen_csr register block: register-select
// encodings on amm_address_i[1:0], config field widths, and the sweep FSM
// state type.
package pkt_gen_csr_pkg;

  // Register select encodings (low two bits of the word address)
  localparam logic [1:0] REG_SIZE    = 2'd0;
  localparam logic [1:0] REG_TOKEN   = 2'd1;
  localparam logic [1:0] REG_FLOW_EN = 2'd2;
  localparam logic [1:0] REG_GLOBAL  = 2'd3;

  // Config field widths driven towards pkt_gen_top
  localparam int SIZE_W  = 16;
  localparam int TOKEN_W = 32;

  typedef enum logic {
    IDLE,
    SWEEP
  } csr_state_t;

endpackage

// File: rtl/pkt_gen_csr_sweep.sv
// pkt_gen_csr_sweep
// Walks one enable value across every flow, one flow per cycle, after a
// GLOBAL register write. It produces a write request in the same cycle the
// request should be registered by the top, so the registered strobes land
// one cycle after the GLOBAL write and then once per cycle after that.
//
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   start_i       GLOBAL write accepted this cycle
//   en_data_i     enable value to sweep (writedata[0] of the GLOBAL write)
//   req_o         request an enable write this cycle (registered by the top)
//   addr_o        flow index of the requested enable write
//   data_o        enable value of the requested enable write
//   busy_o        sweep in progress; drives amm_waitrequest_o
module pkt_gen_csr_sweep
  import pkt_gen_csr_pkg::*;
#(
  parameter int FLOW_CNT = 16,
  localparam int FLOW_CNT_WIDTH = (FLOW_CNT == 1) ? 1 : $clog2(FLOW_CNT)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic                      en_data_i,
  output logic                      req_o,
  output logic [FLOW_CNT_WIDTH-1:0] addr_o,
  output logic                      data_o,
  output logic                      busy_o
);

  // One extra counter bit so FLOW_CNT itself is representable when
  // FLOW_CNT is a power of two.
  localparam logic [FLOW_CNT_WIDTH:0] CNT_END = (FLOW_CNT_WIDTH + 1)'(FLOW_CNT);
  localparam logic [FLOW_CNT_WIDTH:0] CNT_ONE = (FLOW_CNT_WIDTH + 1)'(1);

  csr_state_t              state_q, state_d;
  logic [FLOW_CNT_WIDTH:0] cnt_q, cnt_d;
  logic                    en_q, en_d;

  // Flow 0 is requested in the start cycle itself; cnt_q then holds the
  // next flow to request. Once every flow has been requested the FSM spends
  // one final SWEEP cycle (while the last strobe is on the outputs) and
  // returns to IDLE, so waitrequest covers exactly the strobe cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    req_o   = 1'b0;
    addr_o  = cnt_q[FLOW_CNT_WIDTH-1:0];
    data_o  = en_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = SWEEP;
          cnt_d   = CNT_ONE;
          en_d    = en_data_i;
          req_o   = 1'b1;
          addr_o  = '0;
          data_o  = en_data_i;
        end
      end
      SWEEP: begin
        if (cnt_q == CNT_END) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          req_o = 1'b1;
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q == SWEEP);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
    end
  end

endmodule

// File: rtl/pkt_gen_csr.sv
// pkt_gen_csr
// Avalon-MM slave holding the per-flow configuration of pkt_gen_top.
// Host writes become one-cycle write strobes on the size, token and
// flow-enable config ports; shadow copies give host readback. A GLOBAL
// write sweeps one enable value across all flows via pkt_gen_csr_sweep.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   amm_*                 Avalon-MM slave; address[1:0] = register select,
//                         address[ADDR_W-1:2] = flow index
//   wr_size_*_o           size config port (addr, data, strobe)
//   wr_token_*_o          token config port (addr, data, strobe)
//   wr_flow_en_*_o        flow enable config port (addr, data, strobe)
module pkt_gen_csr
  import pkt_gen_csr_pkg::*;
#(
  parameter int FLOW_CNT = 16,
  localparam int FLOW_CNT_WIDTH = (FLOW_CNT == 1) ? 1 : $clog2(FLOW_CNT),
  localparam int ADDR_W = FLOW_CNT_WIDTH + 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [ADDR_W-1:0]         amm_address_i,
  input  logic                      amm_write_i,
  input  logic [31:0]               amm_writedata_i,
  input  logic                      amm_read_i,
  output logic [31:0]               amm_readdata_o,
  output logic                      amm_readdatavalid_o,
  output logic                      amm_waitrequest_o,
  output logic [FLOW_CNT_WIDTH-1:0] wr_size_addr_o,
  output logic [SIZE_W-1:0]         wr_size_data_o,
  output logic                      wr_size_wr_en_o,
  output logic [FLOW_CNT_WIDTH-1:0] wr_token_addr_o,
  output logic [TOKEN_W-1:0]        wr_token_data_o,
  output logic                      wr_token_wr_en_o,
  output logic [FLOW_CNT_WIDTH-1:0] wr_flow_en_addr_o,
  output logic                      wr_flow_en_data_o,
  output logic                      wr_flow_en_wr_en_o
);

  logic [1:0]                reg_sel;
  logic [FLOW_CNT_WIDTH-1:0] flow_idx;
  logic                      idx_ok;
  logic                      wr_acc;
  logic                      rd_acc;
  logic                      size_wr;
  logic                      token_wr;
  logic                      fe_host_wr;
  logic                      sweep_start;
  logic                      sweep_req;
  logic [FLOW_CNT_WIDTH-1:0] sweep_addr;
  logic                      sweep_data;
  logic                      sweep_busy;

  logic [FLOW_CNT_WIDTH-1:0] size_addr_q, size_addr_d;
  logic [SIZE_W-1:0]         size_data_q, size_data_d;
  logic                      size_wr_en_q, size_wr_en_d;
  logic [FLOW_CNT_WIDTH-1:0] token_addr_q, token_addr_d;
  logic [TOKEN_W-1:0]        token_data_q, token_data_d;
  logic                      token_wr_en_q, token_wr_en_d;
  logic [FLOW_CNT_WIDTH-1:0] fe_addr_q, fe_addr_d;
  logic                      fe_data_q, fe_data_d;
  logic                      fe_wr_en_q, fe_wr_en_d;
  logic [SIZE_W-1:0]         size_shadow_q [FLOW_CNT];
  logic [SIZE_W-1:0]         size_shadow_d [FLOW_CNT];
  logic [TOKEN_W-1:0]        token_shadow_q [FLOW_CNT];
  logic [TOKEN_W-1:0]        token_shadow_d [FLOW_CNT];
  logic [FLOW_CNT-1:0]       en_shadow_q, en_shadow_d;
  logic [31:0]               rd_data_q, rd_data_d;
  logic                      rd_valid_q, rd_valid_d;

  assign reg_sel  = amm_address_i[1:0];
  assign flow_idx = amm_address_i[ADDR_W-1:2];

  // Flow indices beyond FLOW_CNT only exist when FLOW_CNT is not a power
  // of two; otherwise every index the address can carry is a real flow.
  if (FLOW_CNT == (1 << FLOW_CNT_WIDTH)) begin : g_idx_full
    assign idx_ok = 1'b1;
  end else begin : g_idx_check
    assign idx_ok = (flow_idx < FLOW_CNT_WIDTH'(FLOW_CNT));
  end

  // Waitrequest blocks all host accesses during a sweep, which is also what
  // keeps the sweep and the host FLOW_EN path from colliding.
  assign wr_acc      = amm_write_i & ~sweep_busy;
  assign rd_acc      = amm_read_i & ~amm_write_i & ~sweep_busy;
  assign size_wr     = wr_acc && (reg_sel == REG_SIZE) && idx_ok;
  assign token_wr    = wr_acc && (reg_sel == REG_TOKEN) && idx_ok;
  assign fe_host_wr  = wr_acc && (reg_sel == REG_FLOW_EN) && idx_ok;
  assign sweep_start = wr_acc && (reg_sel == REG_GLOBAL);

  pkt_gen_csr_sweep #(
    .FLOW_CNT (FLOW_CNT)
  ) u_sweep (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (sweep_start),
    .en_data_i (amm_writedata_i[0]),
    .req_o     (sweep_req),
    .addr_o    (sweep_addr),
    .data_o    (sweep_data),
    .busy_o    (sweep_busy)
  );

  // Config port registers and shadows. Addr/data hold between writes; the
  // strobe is a single-cycle pulse. The shadow is written at the same edge
  // the strobe goes out, so a read in the following cycle sees the new value.
  always_comb begin
    size_addr_d    = size_addr_q;
    size_data_d    = size_data_q;
    size_wr_en_d   = size_wr;
    token_addr_d   = token_addr_q;
    token_data_d   = token_data_q;
    token_wr_en_d  = token_wr;
    fe_addr_d      = fe_addr_q;
    fe_data_d      = fe_data_q;
    fe_wr_en_d     = fe_host_wr | sweep_req;
    size_shadow_d  = size_shadow_q;
    token_shadow_d = token_shadow_q;
    en_shadow_d    = en_shadow_q;
    if (size_wr) begin
      size_addr_d             = flow_idx;
      size_data_d             = amm_writedata_i[SIZE_W-1:0];
      size_shadow_d[flow_idx] = amm_writedata_i[SIZE_W-1:0];
    end
    if (token_wr) begin
      token_addr_d             = flow_idx;
      token_data_d             = amm_writedata_i[TOKEN_W-1:0];
      token_shadow_d[flow_idx] = amm_writedata_i[TOKEN_W-1:0];
    end
    if (sweep_req) begin
      fe_addr_d               = sweep_addr;
      fe_data_d               = sweep_data;
      en_shadow_d[sweep_addr] = sweep_data;
    end else if (fe_host_wr) begin
      fe_addr_d             = flow_idx;
      fe_data_d             = amm_writedata_i[0];
      en_shadow_d[flow_idx] = amm_writedata_i[0];
    end
  end

  // Read path: one-cycle latency from the shadows. Out-of-range flows read
  // as zero but still return readdatavalid.
  always_comb begin
    rd_valid_d = rd_acc;
    rd_data_d  = '0;
    if (rd_acc) begin
      case (reg_sel)
        REG_SIZE:
          if (idx_ok) rd_data_d = {{(32 - SIZE_W){1'b0}}, size_shadow_q[flow_idx]};
        REG_TOKEN:
          if (idx_ok) rd_data_d = token_shadow_q[flow_idx];
        REG_FLOW_EN:
          if (idx_ok) rd_data_d = {31'h0, en_shadow_q[flow_idx]};
        default:
          rd_data_d = {sweep_busy, 7'h0, 8'(FLOW_CNT - 1), 16'h0};
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      size_addr_q    <= '0;
      size_data_q    <= '0;
      size_wr_en_q   <= 1'b0;
      token_addr_q   <= '0;
      token_data_q   <= '0;
      token_wr_en_q  <= 1'b0;
      fe_addr_q      <= '0;
      fe_data_q      <= 1'b0;
      fe_wr_en_q     <= 1'b0;
      size_shadow_q  <= '{default: '0};
      token_shadow_q <= '{default: '0};
      en_shadow_q    <= '0;
      rd_data_q      <= '0;
      rd_valid_q     <= 1'b0;
    end else begin
      size_addr_q    <= size_addr_d;
      size_data_q    <= size_data_d;
      size_wr_en_q   <= size_wr_en_d;
      token_addr_q   <= token_addr_d;
      token_data_q   <= token_data_d;
      token_wr_en_q  <= token_wr_en_d;
      fe_addr_q      <= fe_addr_d;
      fe_data_q      <= fe_data_d;
      fe_wr_en_q     <= fe_wr_en_d;
      size_shadow_q  <= size_shadow_d;
      token_shadow_q <= token_shadow_d;
      en_shadow_q    <= en_shadow_d;
      rd_data_q      <= rd_data_d;
      rd_valid_q     <= rd_valid_d;
    end
  end

  assign amm_readdata_o      = rd_data_q;
  assign amm_readdatavalid_o = rd_valid_q;
  assign amm_waitrequest_o   = sweep_busy;
  assign wr_size_addr_o      = size_addr_q;
  assign wr_size_data_o      = size_data_q;
  assign wr_size_wr_en_o     = size_wr_en_q;
  assign wr_token_addr_o     = token_addr_q;
  assign wr_token_data_o     = token_data_q;
  assign wr_token_wr_en_o    = token_wr_en_q;
  assign wr_flow_en_addr_o   = fe_addr_q;
  assign wr_flow_en_data_o   = fe_data_q;
  assign wr_flow_en_wr_en_o  = fe_wr_en_q;

endmodule

// File: doc/pkt_gen_csr.md
Name: pkt_gen_csr

Overview:
Avalon-MM slave that owns the per-flow configuration of pkt_gen_top. Host word accesses become the single-cycle write strobes that pkt_gen_top consumes on its size, token and flow-enable config ports. Shadow copies of every programmed value give the host readback. A global register sweeps one enable value across all flows, one flow per cycle.

Parameters:
FLOW_CNT, 16, number of flows; 1..256
FLOW_CNT_WIDTH, (FLOW_CNT==1)?1:$clog2(FLOW_CNT), flow index width (derived, not overridable)
ADDR_W, FLOW_CNT_WIDTH+2, word address width

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
amm_address_i  in  ADDR_W  word address; [1:0]=reg sel, [ADDR_W-1:2]=flow index
amm_write_i  in  1  write request
amm_writedata_i  in  32  write data
amm_read_i  in  1  read request
amm_readdata_o  out  32  read data
amm_readdatavalid_o  out  1  read data valid
amm_waitrequest_o  out  1  stall
wr_size_addr_o  out  FLOW_CNT_WIDTH  flow index for size write
wr_size_data_o  out  16  packet size incl. CRC
wr_size_wr_en_o  out  1  size write strobe
wr_token_addr_o  out  FLOW_CNT_WIDTH  flow index for token write
wr_token_data_o  out  32  token value
wr_token_wr_en_o  out  1  token write strobe
wr_flow_en_addr_o  out  FLOW_CNT_WIDTH  flow index for enable write
wr_flow_en_data_o  out  1  enable value
wr_flow_en_wr_en_o  out  1  enable write strobe

Behaviour:
- Reset: every output 0. All shadow registers 0. FSM to IDLE.
- Reg sel: 0=SIZE (data[15:0]), 1=TOKEN (data[31:0]), 2=FLOW_EN (data[0]), 3=GLOBAL (flow index ignored).
- Flow index >= FLOW_CNT, non-power-of-2 case: write dropped with no strobe. Read returns 0 with readdatavalid.
- Access is accepted when request=1 and waitrequest=0. amm_write_i and amm_read_i together: write wins, read dropped, no readdatavalid.
- Write accepted in cycle N to reg sel 0/1/2: the matching addr/data are registered and wr_en=1 in cycle N+1 only. The shadow is updated at the same edge. Addr/data hold their value until the next write to that port.
- Back-to-back writes give one strobe per accepted write, each one cycle later. No merging, no loss.
- Read accepted in cycle N: readdatavalid=1 with readdata in N+1, otherwise readdatavalid=0.
  - SIZE read: {16'h0, size}. FLOW_EN read: {31'h0, en}.
  - Write in N followed by read of the same register in N+1 returns the new value.
- GLOBAL write in N: FSM IDLE->SWEEP.
  - In cycles N+1..N+FLOW_CNT: wr_flow_en_wr_en_o=1, addr=0..FLOW_CNT-1 ascending, data=writedata[0]. Each shadow en is updated as its strobe fires.
  - SWEEP->IDLE after addr FLOW_CNT-1.
- amm_waitrequest_o = (state==SWEEP). It is a combinational state decode and is 0 in IDLE.
- GLOBAL read: {busy(=0 when accepted), 7'h0, 8'(FLOW_CNT-1), 16'h0}.
- Reset during SWEEP: next edge returns to IDLE with all strobes 0. Shadows clear. No partial sweep resumes.
- Sweep counter is FLOW_CNT_WIDTH+1 bits so there is no wrap at FLOW_CNT=2^n.

Decomposition:
- pkt_gen_csr_pkg holds:
  - reg-sel localparams REG_SIZE=2'd0, REG_TOKEN=2'd1, REG_FLOW_EN=2'd2, REG_GLOBAL=2'd3
  - SIZE_W=16 and TOKEN_W=32
  - typedef csr_state_t {IDLE, SWEEP}
- One sub-module, pkt_gen_csr_sweep: FSM plus flow counter. It emits the enable addr/data/strobe and busy. The top muxes its enable output with the direct FLOW_EN write path; they are exclusive because waitrequest blocks host writes during a sweep.

Test Plan:
- Reset, then read addr {0,SIZE} -> readdatavalid 1 cycle after accept, data 0. All wr_*_wr_en 0 throughout reset.
- Write SIZE flow0=64, SIZE flow1=100 back-to-back -> wr_size_wr_en pulses two consecutive cycles with (addr 0, data 64) then (1, 100). Readback gives 64 and 100.
- Write TOKEN flow0=150, flow1=380 with writedata[31:16]!=0 on SIZE -> token strobes carry 150/380. SIZE truncates to [15:0].
- GLOBAL write data=1 at cycle N -> waitrequest high N+1..N+16. 16 flow_en strobes addr 0..15, data 1. A host write held during the sweep is accepted at N+17 and strobes at N+18.
- Write FLOW_EN flow5=1 and read simultaneously -> strobe addr 5. No readdatavalid.
- Assert rst_i during sweep at flow 7 -> strobes stop the next cycle. Waitrequest 0. GLOBAL read shows busy 0, field FLOW_CNT-1=15.
